// File: rtl/pokey_pot_scan_ctrl.sv
// POKEY potentiometer scan sequencer: dump, release and count, latching each
// pot's count when its comparator crosses and tracking the ALLPOT busy bits.
module pokey_pot_scan_ctrl #(
  parameter int NPOT       = 2,
  parameter int MAX_COUNT  = 228,
  parameter int DUMP_TICKS = 2
) (
  input  logic              o2,
  input  logic              rst_L,
  input  logic              potgo,
  input  logic              fast_scan,
  input  logic              line_tick,
  input  logic [NPOT-1:0]   pot_in,
  output logic [NPOT-1:0]   pot_rel,
  output logic [8*NPOT-1:0] pot_val,
  output logic [NPOT-1:0]   allpot,
  output logic              scan_busy,
  output logic              scan_done
);

  localparam int DW = (DUMP_TICKS > 1) ? $clog2(DUMP_TICKS) : 1;
  localparam logic [DW-1:0] DUMP_LAST = DW'(DUMP_TICKS - 1);
  localparam logic [7:0]    MAX_CNT   = 8'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DUMP  = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t                 state_q;
  logic [7:0]             cnt_q;
  logic [DW-1:0]          dcnt_q;
  logic [NPOT-1:0]        sync1_q;
  logic [NPOT-1:0]        pot_s_q;
  logic [NPOT-1:0]        pot_rel_q;
  logic [NPOT-1:0][7:0]   val_q;
  logic [NPOT-1:0]        allpot_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   tick;

  assign tick      = fast_scan | line_tick;
  assign pot_rel   = pot_rel_q;
  assign pot_val   = val_q;
  assign allpot    = allpot_q;
  assign scan_busy = busy_q;
  assign scan_done = done_q;

  // Comparator inputs are asynchronous to o2.
  always_ff @(posedge o2 or negedge rst_L) begin
    if (!rst_L) begin
      sync1_q <= '0;
      pot_s_q <= '0;
    end else begin
      sync1_q <= pot_in;
      pot_s_q <= sync1_q;
    end
  end

  always_ff @(posedge o2 or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      pot_rel_q <= '1;
      val_q     <= '0;
      allpot_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          pot_rel_q <= '1;
          if (potgo) begin
            state_q  <= DUMP;
            dcnt_q   <= '0;
            allpot_q <= '1;
            busy_q   <= 1'b1;
          end
        end

        DUMP: begin
          if (potgo) begin
            dcnt_q   <= '0;
            allpot_q <= '1;
          end else if (tick) begin
            if (dcnt_q == DUMP_LAST) begin
              state_q   <= COUNT;
              cnt_q     <= '0;
              pot_rel_q <= '0;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
        end

        COUNT: begin
          // The terminal tick always completes the scan, even when a
          // restart arrives on the same cycle.
          if (tick && (cnt_q == MAX_CNT)) begin
            for (int n = 0; n < NPOT; n++) begin
              if (allpot_q[n]) val_q[n] <= MAX_CNT;
            end
            done_q    <= 1'b1;
            pot_rel_q <= '1;
            cnt_q     <= '0;
            if (potgo) begin
              state_q  <= DUMP;
              dcnt_q   <= '0;
              allpot_q <= '1;
              busy_q   <= 1'b1;
            end else begin
              state_q  <= IDLE;
              allpot_q <= '0;
              busy_q   <= 1'b0;
            end
          end else if (potgo) begin
            state_q   <= DUMP;
            dcnt_q    <= '0;
            allpot_q  <= '1;
            pot_rel_q <= '1;
          end else if (tick) begin
            for (int n = 0; n < NPOT; n++) begin
              if (allpot_q[n] && pot_s_q[n]) begin
                val_q[n]    <= cnt_q;
                allpot_q[n] <= 1'b0;
              end
            end
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: begin
          state_q   <= IDLE;
          pot_rel_q <= '1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule
